pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage core. It drives the write enables of PC and IF/ID, and the bubble request into the ID/EX register. It sequences three cases: branch resolution windows, load-use interlocks, and memory-not-ready freezes. It sits beside the decode stage, watches the decoded instruction and the EX/MEM status, and keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/pipe_hazard_ctrl.sv | 105 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Decode-side pipeline sequencer: branch resolution window, load-use interlock,
// memory freeze, and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int BR_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [15:0]      i_ir_id,
  input  logic [1:0]       i_op_ex,
  input  logic [2:0]       i_dr_ex,
  input  logic             i_branch_ex,
  input  logic             i_mem_ready,
  output logic             o_pc_we,
  output logic             o_pc_sel,
  output logic             o_if_id_we,
  output logic             o_if_id_nop,
  output logic             o_id_ex_bubble,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam logic [0:0] S_RUN = 1'b0;
  localparam logic [0:0] S_BRW = 1'b1;
  localparam logic [3:0] OPC_ADD = 4'b0001;
  localparam logic [3:0] OPC_LDW = 4'b0110;
  localparam logic [3:0] OPC_STW = 4'b0111;
  localparam logic [1:0] OPX_LDW = 2'b10;
  localparam logic [2:0] WLOAD   = 3'(BR_LAT - 1);

  logic [0:0]       r_state, w_state_nxt;
  logic [2:0]       r_wcnt, w_wcnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [3:0] w_opc;
  logic       w_is_br, w_rd_sr1, w_rd_sr2, w_lu;
  logic [2:0] w_sr2;

  // An all-zero word is a NOP: not a branch, and it reads no registers.
  assign w_opc    = i_ir_id[15:12];
  assign w_is_br  = (w_opc == 4'b0000) && (i_ir_id != 16'h0000);
  assign w_rd_sr1 = (w_opc == OPC_ADD) || (w_opc == OPC_LDW) || (w_opc == OPC_STW);
  assign w_rd_sr2 = (w_opc == OPC_STW) || ((w_opc == OPC_ADD) && !i_ir_id[5]);
  assign w_sr2    = (w_opc == OPC_STW) ? i_ir_id[11:9] : i_ir_id[2:0];
  assign w_lu     = (i_op_ex == OPX_LDW) &&
                    ((w_rd_sr1 && (i_dr_ex == i_ir_id[8:6])) ||
                     (w_rd_sr2 && (i_dr_ex == w_sr2)));

  always_comb begin
    o_pc_we        = 1'b0;
    o_pc_sel       = 1'b0;
    o_if_id_we     = 1'b0;
    o_if_id_nop    = 1'b0;
    o_id_ex_bubble = 1'b0;
    w_state_nxt    = r_state;
    w_wcnt_nxt     = r_wcnt;
    if (!i_mem_ready) begin
      // freeze: everything held, nothing loads
    end else if (r_state == S_BRW) begin
      o_if_id_we  = 1'b1;
      o_if_id_nop = 1'b1;
      if (r_wcnt != 3'd0) begin
        w_wcnt_nxt = r_wcnt - 3'd1;
      end else begin
        o_pc_we     = 1'b1;
        o_pc_sel    = i_branch_ex;
        w_state_nxt = S_RUN;
      end
    end else if (w_is_br) begin
      o_if_id_we  = 1'b1;
      o_if_id_nop = 1'b1;
      w_state_nxt = S_BRW;
      w_wcnt_nxt  = WLOAD;
    end else if (w_lu) begin
      o_id_ex_bubble = 1'b1;
    end else begin
      o_pc_we    = 1'b1;
      o_if_id_we = 1'b1;
    end
    if (!i_rst_n) begin
      o_pc_we        = 1'b0;
      o_pc_sel       = 1'b0;
      o_if_id_we     = 1'b0;
      o_if_id_nop    = 1'b1;
      o_id_ex_bubble = 1'b1;
    end
  end

  assign o_busy      = i_rst_n && (r_state == S_BRW);
  assign o_stall_cnt = r_stall_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_RUN;
      r_wcnt      <= 3'd0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      if (!o_pc_we && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: DUT A (BR_LAT=3, 16-bit counter) and DUT B (BR_LAT=1, 4-bit counter).
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // per-DUT input bundles
  logic [15:0] a_ir, b_ir;
  logic [1:0]  a_op, b_op;
  logic [2:0]  a_dr, b_dr;
  logic        a_bex, b_bex, a_mr, b_mr;
  logic        a_pcwe, a_sel, a_ifwe, a_nop, a_bub, a_busy;
  logic        b_pcwe, b_sel, b_ifwe, b_nop, b_bub, b_busy;
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt;

  pipe_hazard_ctrl #(.BR_LAT(3), .CNT_W(16)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_ir_id(a_ir), .i_op_ex(a_op), .i_dr_ex(a_dr),
    .i_branch_ex(a_bex), .i_mem_ready(a_mr), .o_pc_we(a_pcwe), .o_pc_sel(a_sel),
    .o_if_id_we(a_ifwe), .o_if_id_nop(a_nop), .o_id_ex_bubble(a_bub), .o_busy(a_busy),
    .o_stall_cnt(a_cnt));

  pipe_hazard_ctrl #(.BR_LAT(1), .CNT_W(4)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_ir_id(b_ir), .i_op_ex(b_op), .i_dr_ex(b_dr),
    .i_branch_ex(b_bex), .i_mem_ready(b_mr), .o_pc_we(b_pcwe), .o_pc_sel(b_sel),
    .o_if_id_we(b_ifwe), .o_if_id_nop(b_nop), .o_id_ex_bubble(b_bub), .o_busy(b_busy),
    .o_stall_cnt(b_cnt));

  // outs = {pc_we, pc_sel, if_id_we, if_id_nop, id_ex_bubble, busy}
  localparam logic [5:0] O_RST  = 6'b000110;
  localparam logic [5:0] O_RUN  = 6'b101000;
  localparam logic [5:0] O_DET  = 6'b001100;
  localparam logic [5:0] O_WAIT = 6'b001101;
  localparam logic [5:0] O_TKN  = 6'b111101;
  localparam logic [5:0] O_NTK  = 6'b101101;
  localparam logic [5:0] O_LU   = 6'b000010;
  localparam logic [5:0] O_FRZR = 6'b000000;
  localparam logic [5:0] O_FRZW = 6'b000001;

  typedef struct {
    string       tag;
    bit          dut_b;
    logic [5:0]  outs;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic idle_a();
    a_ir = 16'h0000; a_op = 2'b01; a_dr = 3'd0; a_bex = 1'b0; a_mr = 1'b1;
  endtask

  task automatic idle_b();
    b_ir = 16'h0000; b_op = 2'b01; b_dr = 3'd0; b_bex = 1'b0; b_mr = 1'b1;
  endtask

  // Pop one expectation at the falling edge and compare it, then advance past the next rising edge.
  task automatic check_and_advance();
    exp_t e;
    logic [5:0]  o;
    logic [15:0] c;
    @(negedge clk);
    e = sb.pop_front();
    if (e.dut_b) begin
      o = {b_pcwe, b_sel, b_ifwe, b_nop, b_bub, b_busy};
      c = {12'd0, b_cnt};
    end else begin
      o = {a_pcwe, a_sel, a_ifwe, a_nop, a_bub, a_busy};
      c = a_cnt;
    end
    n_cmp++;
    assert (o === e.outs) else begin
      n_err++;
      $error("FAIL %s outs: got %b want %b", e.tag, o, e.outs);
    end
    n_cmp++;
    assert (c === e.cnt) else begin
      n_err++;
      $error("FAIL %s stall_cnt: got %0d want %0d", e.tag, c, e.cnt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step_a(input string tag, input logic [15:0] ir, input logic [1:0] op,
                        input logic [2:0] dr, input logic bex, input logic mr,
                        input logic [5:0] outs, input logic [15:0] cnt);
    exp_t e;
    a_ir = ir; a_op = op; a_dr = dr; a_bex = bex; a_mr = mr;
    idle_b();
    e.tag = tag; e.dut_b = 1'b0; e.outs = outs; e.cnt = cnt;
    sb.push_back(e);
    check_and_advance();
  endtask

  task automatic step_b(input string tag, input logic [15:0] ir, input logic bex,
                        input logic mr, input logic [5:0] outs, input logic [15:0] cnt);
    exp_t e;
    b_ir = ir; b_op = 2'b01; b_dr = 3'd0; b_bex = bex; b_mr = mr;
    idle_a();
    e.tag = tag; e.dut_b = 1'b1; e.outs = outs; e.cnt = cnt;
    sb.push_back(e);
    check_and_advance();
  endtask

  initial begin
    idle_a();
    idle_b();
    @(posedge clk);
    #1;
    step_a("reset", 16'h0000, 2'b01, 3'd0, 1'b0, 1'b1, O_RST, 16'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      step_a("add_run", 16'h1042, 2'b01, 3'd0, 1'b0, 1'b1, O_RUN, 16'd0);

    // not-taken branch, BR_LAT=3
    step_a("br3_detect", 16'h0E05, 2'b01, 3'd0, 1'b0, 1'b1, O_DET, 16'd0);
    step_a("br3_wait1",  16'h0000, 2'b00, 3'd0, 1'b0, 1'b1, O_WAIT, 16'd1);
    step_a("br3_wait2",  16'h0000, 2'b01, 3'd0, 1'b0, 1'b1, O_WAIT, 16'd2);
    step_a("br3_resolve_nt", 16'h0000, 2'b01, 3'd0, 1'b0, 1'b1, O_NTK, 16'd3);
    step_a("br3_after",  16'h1042, 2'b01, 3'd0, 1'b0, 1'b1, O_RUN, 16'd3);

    // load-use variants
    step_a("lu_add_sr1",  16'h14C2, 2'b10, 3'd3, 1'b0, 1'b1, O_LU, 16'd3);
    step_a("lu_release",  16'h14C2, 2'b01, 3'd3, 1'b0, 1'b1, O_RUN, 16'd4);
    step_a("lu_other_dr", 16'h14C2, 2'b10, 3'd5, 1'b0, 1'b1, O_RUN, 16'd4);
    step_a("lu_stw_sr2",  16'h7640, 2'b10, 3'd3, 1'b0, 1'b1, O_LU, 16'd4);
    step_a("lu_release2", 16'h7640, 2'b01, 3'd3, 1'b0, 1'b1, O_RUN, 16'd5);
    step_a("lu_add_imm",  16'h1463, 2'b10, 3'd3, 1'b0, 1'b1, O_RUN, 16'd5);
    step_a("lu_nop",      16'h0000, 2'b10, 3'd0, 1'b0, 1'b1, O_RUN, 16'd5);
    step_a("lu_ldw_sr1",  16'h6440, 2'b10, 3'd1, 1'b0, 1'b1, O_LU, 16'd5);
    step_a("lu_b2b",      16'h6440, 2'b10, 3'd1, 1'b0, 1'b1, O_LU, 16'd6);
    step_a("lu_release3", 16'h6440, 2'b01, 3'd1, 1'b0, 1'b1, O_RUN, 16'd7);

    // taken branch with two freeze cycles in the resolve cycle
    step_a("brf_detect", 16'h0E05, 2'b01, 3'd0, 1'b0, 1'b1, O_DET, 16'd7);
    step_a("brf_wait1",  16'h0000, 2'b00, 3'd0, 1'b0, 1'b1, O_WAIT, 16'd8);
    step_a("brf_wait2",  16'h0000, 2'b01, 3'd0, 1'b0, 1'b1, O_WAIT, 16'd9);
    step_a("brf_frz1",   16'h0000, 2'b01, 3'd0, 1'b1, 1'b0, O_FRZW, 16'd10);
    step_a("brf_frz2",   16'h0000, 2'b01, 3'd0, 1'b1, 1'b0, O_FRZW, 16'd11);
    step_a("brf_resolve_t", 16'h0000, 2'b01, 3'd0, 1'b1, 1'b1, O_TKN, 16'd12);
    step_a("brf_after",  16'h1042, 2'b01, 3'd0, 1'b0, 1'b1, O_RUN, 16'd12);

    // freeze coincident with a branch, then reset mid-window
    step_a("brz_frz",    16'h0E05, 2'b01, 3'd0, 1'b0, 1'b0, O_FRZR, 16'd12);
    step_a("brz_detect", 16'h0E05, 2'b01, 3'd0, 1'b0, 1'b1, O_DET, 16'd13);
    step_a("brz_wait1",  16'h0000, 2'b00, 3'd0, 1'b0, 1'b1, O_WAIT, 16'd14);
    rst_n = 1'b0;
    step_a("rst_mid_br", 16'h0000, 2'b01, 3'd0, 1'b0, 1'b1, O_RST, 16'd0);
    rst_n = 1'b1;
    step_a("rst_after",  16'h1042, 2'b01, 3'd0, 1'b0, 1'b1, O_RUN, 16'd0);

    // freeze coincident with load-use
    step_a("luz_frz",    16'h14C2, 2'b10, 3'd3, 1'b0, 1'b0, O_FRZR, 16'd0);
    step_a("luz_lu",     16'h14C2, 2'b10, 3'd3, 1'b0, 1'b1, O_LU, 16'd1);
    step_a("luz_after",  16'h14C2, 2'b01, 3'd3, 1'b0, 1'b1, O_RUN, 16'd2);

    // DUT B: BR_LAT=1 taken branch, then counter saturation
    step_b("b_detect",  16'h0E05, 1'b0, 1'b1, O_DET, 16'd0);
    step_b("b_resolve", 16'h0000, 1'b1, 1'b1, O_TKN, 16'd1);
    step_b("b_after",   16'h1042, 1'b0, 1'b1, O_RUN, 16'd1);
    for (int k = 0; k < 20; k++)
      step_b("b_sat_frz", 16'h1042, 1'b0, 1'b0, O_FRZR, (k + 1 > 15) ? 16'd15 : 16'(k + 1));
    step_b("b_sat_hold1", 16'h1042, 1'b0, 1'b1, O_RUN, 16'd15);
    step_b("b_sat_hold2", 16'h1042, 1'b0, 1'b1, O_RUN, 16'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
